// File: rtl/bcd_stopwatch_if.sv
// Control and display bus between the button debouncers, bcd_stopwatch and the 7-segment driver.
interface bcd_stopwatch_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  dir;
  logic                  lap;
  logic [4*DIGITS-1:0]   count_o;
  logic                  tick_o;
  logic                  wrap_o;
  logic                  running_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   lap_o;
  logic                  lap_valid_o;

  modport master (
    output start, stop, clear, load, load_val, dir, lap,
    input  count_o, tick_o, wrap_o, running_o, done_o, lap_o, lap_valid_o
  );

  modport slave (
    input  start, stop, clear, load, load_val, dir, lap,
    output count_o, tick_o, wrap_o, running_o, done_o, lap_o, lap_valid_o
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// Start/stop packed-BCD stopwatch/timer with prescaler, pause/resume and wrap/done flags.
// Optional lap capture register is enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 500000
) (
  input logic            clock,
  input logic            reset,
  bcd_stopwatch_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  count;
  logic [PW-1:0] presc;
  logic          dir_q;
  logic          tick_q;
  logic          wrap_q;

  logic          take_load;
  logic          take_stop;
  logic          take_start;
  logic          advance;
  logic          tick_now;
  logic [W-1:0]  count_inc;
  logic [W-1:0]  count_dec;
  logic [W-1:0]  load_clamped;
  logic          all_nines;
  logic          dec_zero;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Per-digit clamp of the preset and all-nines detection for the up-wrap flag
  always_comb begin
    load_clamped = bus.load_val;
    all_nines    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
      if (count[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
    end
  end

  assign count_inc = bcd_inc(count);
  assign count_dec = bcd_dec(count);
  assign dec_zero  = (count_dec == '0);

  // Command decode: an ignored command never blocks a lower-priority one, except that
  // stop always suppresses start in the same cycle.
  always_comb begin
    take_load  = 1'b0;
    take_stop  = 1'b0;
    take_start = 1'b0;
    advance    = 1'b0;
    tick_now   = 1'b0;
    if (!bus.clear) begin
      take_load  = bus.load && (state != RUN);
      take_stop  = bus.stop && (state == RUN);
      take_start = !take_load && !bus.stop && bus.start &&
                   ((state == IDLE) || (state == PAUSE));
      advance    = (state == RUN) && !bus.stop;
      tick_now   = advance && (presc == PRESC_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else if (take_load || take_stop) begin
      state_next = PAUSE;
    end else if (take_start) begin
      state_next = (bus.dir && (count == '0)) ? DONE : RUN;
    end else if (tick_now && dir_q && dec_zero) begin
      state_next = DONE;
    end
  end

  // Count, prescaler and pulse flags; a stop edge leaves the prescaler phase untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      presc  <= '0;
      dir_q  <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.clear) begin
        count <= '0;
        presc <= '0;
      end else if (take_load) begin
        count <= load_clamped;
        presc <= '0;
      end else if (take_start) begin
        dir_q <= bus.dir;
      end else if (advance) begin
        if (tick_now) begin
          presc  <= '0;
          tick_q <= 1'b1;
          if (dir_q) begin
            count <= count_dec;
          end else begin
            count  <= count_inc;
            wrap_q <= all_nines;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_q;
  logic         lap_valid_q;

  // Captures the pre-tick count so a lap on a tick edge shows the value the user saw
  always_ff @(posedge clock) begin
    if (reset) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else if (bus.clear) begin
      lap_valid_q <= 1'b0;
    end else if (bus.lap && (state == RUN)) begin
      lap_q       <= count;
      lap_valid_q <= 1'b1;
    end
  end
`else
  logic [W-1:0] lap_q;
  logic         lap_valid_q;
  logic         unused_lap;

  assign lap_q       = '0;
  assign lap_valid_q = 1'b0;
  assign unused_lap  = bus.lap;
`endif

  always_comb begin
    bus.count_o     = count;
    bus.tick_o      = tick_q;
    bus.wrap_o      = wrap_q;
    bus.running_o   = (state == RUN);
    bus.done_o      = (state == DONE);
    bus.lap_o       = lap_q;
    bus.lap_valid_o = lap_valid_q;
  end
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Table-driven self-checking bench for bcd_stopwatch (DIGITS=2, TICK_DIV=5).
// Lap expectations follow STOPWATCH_LAP_EN when the bench is compiled with it.
module tb_bcd_stopwatch;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  bcd_stopwatch_if #(.DIGITS(2)) bus ();

  bcd_stopwatch #(.DIGITS(2), .TICK_DIV(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic       dir;
    logic       lap;
    logic [7:0] loadVal;
    int         extra;
    logic [7:0] expCount;
    logic       expTick;
    logic       expWrap;
    logic       expRunning;
    logic       expDone;
    logic       expLapValid;
    logic [7:0] expLap;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, logic st, logic sp, logic cl, logic ld,
                                 logic dr, logic lp, logic [7:0] lv, int extra,
                                 logic [7:0] cnt, logic tk, logic wr, logic rn,
                                 logic dn, logic lval, logic [7:0] lapv);
    vec_t v;
    v.name = name; v.start = st; v.stop = sp; v.clear = cl; v.load = ld;
    v.dir = dr; v.lap = lp; v.loadVal = lv; v.extra = extra;
    v.expCount = cnt; v.expTick = tk; v.expWrap = wr; v.expRunning = rn;
    v.expDone = dn; v.expLapValid = lval; v.expLap = lapv;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
    bus.dir = 1'b0; bus.lap = 1'b0; bus.load_val = 8'h00;
  endtask

  // Drive one vector for a single edge, then idle for `extra` more edges
  task automatic applyStimulus(input vec_t v);
    bus.start = v.start; bus.stop = v.stop; bus.clear = v.clear; bus.load = v.load;
    bus.dir = v.dir; bus.lap = v.lap; bus.load_val = v.loadVal;
    @(posedge clock);
    #1;
    idleInputs();
    for (int i = 0; i < v.extra; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkAll(input vec_t v);
    logic lapValidExp;
    lapValidExp = LAP_ON ? v.expLapValid : 1'b0;
    checkOutput({v.name, ".count"},   bus.count_o,            v.expCount);
    checkOutput({v.name, ".tick"},    {7'd0, bus.tick_o},     {7'd0, v.expTick});
    checkOutput({v.name, ".wrap"},    {7'd0, bus.wrap_o},     {7'd0, v.expWrap});
    checkOutput({v.name, ".running"}, {7'd0, bus.running_o},  {7'd0, v.expRunning});
    checkOutput({v.name, ".done"},    {7'd0, bus.done_o},     {7'd0, v.expDone});
    checkOutput({v.name, ".lapv"},    {7'd0, bus.lap_valid_o}, {7'd0, lapValidExp});
    if (lapValidExp || !LAP_ON) begin
      checkOutput({v.name, ".lap"}, bus.lap_o, LAP_ON ? v.expLap : 8'h00);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idleInputs();

    //      name        st sp cl ld dr lp  lval  ex  cnt   tk wr rn dn lv lap
    addVec("t1_s3",      1, 0, 0, 0, 0, 0, 8'h00, 3, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    addVec("t1_s4_dir",  0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    addVec("t1_s5",      0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1, 0, 1, 0, 0, 8'h00);
    addVec("t1_s6",      0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 1, 0, 0, 8'h00);
    addVec("t1_s50",     0, 0, 0, 0, 0, 0, 8'h00, 43, 8'h10, 1, 0, 1, 0, 0, 8'h00);
    addVec("t2_load_ign",0, 0, 0, 1, 0, 0, 8'h99, 0, 8'h10, 0, 0, 1, 0, 0, 8'h00);
    addVec("t2_clear",   0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t2_load99",  0, 0, 0, 1, 0, 0, 8'h99, 0, 8'h99, 0, 0, 0, 0, 0, 8'h00);
    addVec("t2_s4",      1, 0, 0, 0, 0, 0, 8'h00, 4, 8'h99, 0, 0, 1, 0, 0, 8'h00);
    addVec("t2_wrap",    0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
    addVec("t2_after",   0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    addVec("t3_clear",   0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t3_load02",  0, 0, 0, 1, 0, 0, 8'h02, 0, 8'h02, 0, 0, 0, 0, 0, 8'h00);
    addVec("t3_s4",      1, 0, 0, 0, 1, 0, 8'h00, 4, 8'h02, 0, 0, 1, 0, 0, 8'h00);
    addVec("t3_s5",      0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 1, 0, 1, 0, 0, 8'h00);
    addVec("t3_done",    0, 0, 0, 0, 0, 0, 8'h00, 4, 8'h00, 1, 0, 0, 1, 0, 8'h00);
    addVec("t3_start_ign",1,0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00);
    addVec("t3_load5A",  0, 0, 0, 1, 0, 0, 8'h5A, 0, 8'h59, 0, 0, 0, 0, 0, 8'h00);
    addVec("t4_clear",   0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t4_s6",      1, 0, 0, 0, 0, 0, 8'h00, 6, 8'h01, 0, 0, 1, 0, 0, 8'h00);
    addVec("t4_s7",      0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 1, 0, 0, 8'h00);
    addVec("t4_stop",    0, 1, 0, 0, 0, 0, 8'h00, 0, 8'h01, 0, 0, 0, 0, 0, 8'h00);
    addVec("t4_paused",  0, 0, 0, 0, 0, 0, 8'h00, 19, 8'h01, 0, 0, 0, 0, 0, 8'h00);
    addVec("t4_r2",      1, 0, 0, 0, 0, 0, 8'h00, 2, 8'h01, 0, 0, 1, 0, 0, 8'h00);
    addVec("t4_r3",      0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h02, 1, 0, 1, 0, 0, 8'h00);
    addVec("t6_r8",      0, 0, 0, 0, 0, 0, 8'h00, 4, 8'h03, 1, 0, 1, 0, 0, 8'h00);
    addVec("t6_lap",     0, 0, 0, 0, 0, 1, 8'h00, 0, 8'h03, 0, 0, 1, 0, 1, 8'h03);
    addVec("t6_r13",     0, 0, 0, 0, 0, 0, 8'h00, 3, 8'h04, 1, 0, 1, 0, 1, 8'h03);
    addVec("t5_clear",   0, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t5_startstop",1,1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t5_stay",    0, 0, 0, 0, 0, 0, 8'h00, 9, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t5_clrload", 0, 0, 1, 1, 0, 0, 8'h47, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    addVec("t5_down0",   1, 0, 0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00);

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset.count",   bus.count_o,             8'h00);
    checkOutput("reset.running", {7'd0, bus.running_o},   8'h00);
    checkOutput("reset.done",    {7'd0, bus.done_o},      8'h00);
    checkOutput("reset.lapv",    {7'd0, bus.lap_valid_o}, 8'h00);
    checkOutput("reset.lap",     bus.lap_o,               8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkAll(vecs[i]);
    end

    // Reset lands exactly on what would have been a tick edge
    bus.clear = 1'b1;
    @(posedge clock); #1;
    idleInputs();
    bus.load = 1'b1; bus.load_val = 8'h35;
    @(posedge clock); #1;
    idleInputs();
    bus.start = 1'b1; bus.lap = 1'b1;
    @(posedge clock); #1;
    idleInputs();
    repeat (4) begin
      @(posedge clock); #1;
    end
    checkOutput("rst_mid.pre_count",   bus.count_o,           8'h35);
    checkOutput("rst_mid.pre_running", {7'd0, bus.running_o}, 8'h01);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rst_mid.count",   bus.count_o,             8'h00);
    checkOutput("rst_mid.tick",    {7'd0, bus.tick_o},      8'h00);
    checkOutput("rst_mid.wrap",    {7'd0, bus.wrap_o},      8'h00);
    checkOutput("rst_mid.running", {7'd0, bus.running_o},   8'h00);
    checkOutput("rst_mid.done",    {7'd0, bus.done_o},      8'h00);
    checkOutput("rst_mid.lapv",    {7'd0, bus.lap_valid_o}, 8'h00);
    checkOutput("rst_mid.lap",     bus.lap_o,               8'h00);
    repeat (6) begin
      @(posedge clock); #1;
    end
    checkOutput("rst_mid.idle_count",   bus.count_o,           8'h00);
    checkOutput("rst_mid.idle_running", {7'd0, bus.running_o}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
